// File: rtl/sc_fifo_stream_rd.sv
// Read-side drain engine for a show-ahead sc_fifo.
// Pops words into a 2-entry buffer and streams them out with tlast framing.
module sc_fifo_stream_rd #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PKT_LEN    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  fifo_rd_o,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
   input  logic                  fifo_empty_i,
   output logic                  tvalid_o,
   output logic [DATA_WIDTH-1:0] tdata_o,
   output logic                  tlast_o,
   input  logic                  tready_i,
   output logic [15:0]           pkt_cnt_o
);

   localparam int unsigned IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] main_data_q;
   logic                  main_last_q;
   logic [DATA_WIDTH-1:0] skid_data_q;
   logic                  skid_last_q;
   logic [IW-1:0]         idx_q;
   logic [15:0]           pkt_cnt_q;

   logic pop;
   logic out;
   logic cap_last;

   // Pop depends only on registered occupancy, never on tready_i.
   assign pop      = rst_i & ~fifo_empty_i & (state_q != ST_TWO);
   assign tvalid_o = (state_q != ST_EMPTY);
   assign out      = tvalid_o & tready_i;
   assign cap_last = (idx_q == LAST_IDX);

   assign fifo_rd_o = pop;
   assign tdata_o   = main_data_q;
   assign tlast_o   = main_last_q;
   assign pkt_cnt_o = pkt_cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_EMPTY;
         main_data_q <= '0;
         main_last_q <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
         idx_q       <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         if (pop) begin
            idx_q <= cap_last ? '0 : idx_q + 1'b1;
         end
         if (out && main_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
         end
         unique case (state_q)
            ST_EMPTY: begin
               if (pop) begin
                  main_data_q <= fifo_rd_data_i;
                  main_last_q <= cap_last;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (pop && out) begin
                  main_data_q <= fifo_rd_data_i;
                  main_last_q <= cap_last;
               end else if (pop) begin
                  skid_data_q <= fifo_rd_data_i;
                  skid_last_q <= cap_last;
                  state_q     <= ST_TWO;
               end else if (out) begin
                  state_q <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out) begin
                  main_data_q <= skid_data_q;
                  main_last_q <= skid_last_q;
                  state_q     <= ST_ONE;
               end
            end
            default: state_q <= ST_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_sc_fifo_stream_rd.sv
// Directed bench for sc_fifo_stream_rd against an 8-deep show-ahead FIFO model.
// A second instance with PKT_LEN=1 is fed by a simple counting source.
module tb_sc_fifo_stream_rd;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fifo_rd;
   logic [7:0] fifo_rd_data;
   logic       fifo_empty;
   logic       tvalid;
   logic [7:0] tdata;
   logic       tlast;
   logic       tready;
   logic [15:0] pkt_cnt;

   logic       rd_b;
   logic [7:0] data_b;
   logic       empty_b;
   logic       tvalid_b;
   logic [7:0] tdata_b;
   logic       tlast_b;
   logic       tready_b;
   logic [15:0] pkt_cnt_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sc_fifo_stream_rd #(.DATA_WIDTH(8), .PKT_LEN(4)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .fifo_rd_o(fifo_rd), .fifo_rd_data_i(fifo_rd_data),
      .fifo_empty_i(fifo_empty),
      .tvalid_o(tvalid), .tdata_o(tdata), .tlast_o(tlast),
      .tready_i(tready), .pkt_cnt_o(pkt_cnt)
   );

   sc_fifo_stream_rd #(.DATA_WIDTH(8), .PKT_LEN(1)) dut_b (
      .clk_i(clk), .rst_i(rst_n),
      .fifo_rd_o(rd_b), .fifo_rd_data_i(data_b),
      .fifo_empty_i(empty_b),
      .tvalid_o(tvalid_b), .tdata_o(tdata_b), .tlast_o(tlast_b),
      .tready_i(tready_b), .pkt_cnt_o(pkt_cnt_b)
   );

   // Show-ahead FIFO model, 8 words, with its own synchronous clear.
   logic       fclr;
   logic       wr_en;
   logic [7:0] wr_data;
   logic [7:0] fmem [8];
   logic [2:0] fwp;
   logic [2:0] frp;
   logic [3:0] fcnt;
   logic       do_wr;

   assign fifo_empty   = (fcnt == 4'd0);
   assign fifo_rd_data = fmem[frp];
   assign do_wr        = wr_en && (fcnt < 4'd8);

   always @(posedge clk) begin
      if (fclr) begin
         fwp  <= '0;
         frp  <= '0;
         fcnt <= '0;
      end else begin
         if (do_wr) begin
            fmem[fwp] <= wr_data;
            fwp <= fwp + 3'd1;
         end
         if (fifo_rd) frp <= frp + 3'd1;
         fcnt <= fcnt + {3'd0, do_wr} - {3'd0, fifo_rd};
      end
   end

   // Counting source for the PKT_LEN=1 instance: words 1..5.
   logic       b_en;
   logic [3:0] cnt_b;
   assign data_b  = {4'd0, cnt_b} + 8'd1;
   assign empty_b = !b_en || (cnt_b >= 4'd5);

   always @(posedge clk) begin
      if (!b_en) cnt_b <= '0;
      else if (rd_b) cnt_b <= cnt_b + 4'd1;
   end

   // Monitors sample at the falling edge; inputs change just after rising edges.
   int         cyc = 0;
   logic [7:0] bd[$];
   logic       bl[$];
   int         bc[$];
   logic [7:0] bbd[$];
   logic       bbl[$];
   int         npop = 0;
   int         rd_empty_err = 0;
   int         stab_err = 0;
   logic       hold_q = 1'b0;
   logic [7:0] hold_d;
   logic       hold_l;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fifo_rd) npop++;
      if (fifo_rd && fifo_empty) rd_empty_err++;
      if (rst_n && tvalid && tready) begin
         bd.push_back(tdata);
         bl.push_back(tlast);
         bc.push_back(cyc);
      end
      if (rst_n && tvalid_b && tready_b) begin
         bbd.push_back(tdata_b);
         bbl.push_back(tlast_b);
      end
      if (rst_n && hold_q && (!tvalid || tdata !== hold_d || tlast !== hold_l))
         stab_err++;
      hold_q = rst_n && tvalid && !tready;
      hold_d = tdata;
      hold_l = tlast;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick(1);
      wr_en   = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int bound, input string name);
      int k = 0;
      while (bd.size() < n && k < bound) begin
         tick(1);
         k++;
      end
      checks++;
      if (bd.size() < n) begin
         errors++;
         $display("FAIL %s timeout: got %0d beats, need %0d", name, bd.size(), n);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      fclr  = 1'b1;
      tick(2);
      fclr = 1'b0;
      wr(8'hA1);
      wr(8'hA2);
      wr(8'hA3);
      tick(2);
      checks++;
      if (fifo_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_rd: got %b need 0", fifo_rd);
      end
      checks++;
      if (tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_tvalid: got %b need 0", tvalid);
      end
      checks++;
      if (tdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_tdata: got %h need 00", tdata);
      end
      checks++;
      if (tlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_tlast: got %b need 0", tlast);
      end
      checks++;
      if (pkt_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_pkt: got %0d need 0", pkt_cnt);
      end
      fclr = 1'b1;
      tick(1);
      fclr  = 1'b0;
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_stream;
      bd.delete(); bl.delete(); bc.delete();
      tready = 1'b1;
      for (int i = 1; i <= 8; i++) wr(8'(i));
      wait_beats(8, 40, "stream");
      tick(2);
      for (int i = 0; i < 8 && i < bd.size(); i++) begin
         checks++;
         if (bd[i] !== 8'(i + 1) || bl[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL stream_beat%0d: got %h/%b need %h/%b",
                     i, bd[i], bl[i], 8'(i + 1), (i % 4 == 3));
         end
      end
      for (int i = 1; i < 8 && i < bc.size(); i++) begin
         checks++;
         if (bc[i] !== bc[0] + i) begin
            errors++;
            $display("FAIL stream_bubble%0d: got cycle %0d need %0d",
                     i, bc[i], bc[0] + i);
         end
      end
      checks++;
      if (pkt_cnt !== 16'd2) begin
         errors++;
         $display("FAIL stream_pkt: got %0d need 2", pkt_cnt);
      end
   endtask

   task automatic test_backpressure;
      bd.delete(); bl.delete(); bc.delete();
      tready = 1'b0;
      tick(1);
      npop = 0;
      for (int i = 0; i < 8; i++) wr(8'h11 + 8'(i));
      tick(4);
      checks++;
      if (npop !== 2) begin
         errors++;
         $display("FAIL bp_pops: got %0d need 2", npop);
      end
      checks++;
      if (fcnt !== 4'd6) begin
         errors++;
         $display("FAIL bp_used: got %0d need 6", fcnt);
      end
      checks++;
      if (tvalid !== 1'b1 || tdata !== 8'h11) begin
         errors++;
         $display("FAIL bp_head: got %b/%h need 1/11", tvalid, tdata);
      end
      tready = 1'b1;
      wait_beats(8, 40, "bp_drain");
      tick(3);
      checks++;
      if (bd.size() !== 8) begin
         errors++;
         $display("FAIL bp_count: got %0d need 8", bd.size());
      end
      for (int i = 0; i < 8 && i < bd.size(); i++) begin
         checks++;
         if (bd[i] !== 8'h11 + 8'(i) || bl[i] !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL bp_beat%0d: got %h/%b need %h/%b",
                     i, bd[i], bl[i], 8'h11 + 8'(i), (i % 4 == 3));
         end
      end
      checks++;
      if (pkt_cnt !== 16'd4) begin
         errors++;
         $display("FAIL bp_pkt: got %0d need 4", pkt_cnt);
      end
   endtask

   task automatic test_random;
      logic [7:0] ed[$];
      int nw = 0;
      int k = 0;
      int bad_d = 0;
      int bad_l = 0;
      bd.delete(); bl.delete(); bc.delete();
      stab_err = 0;
      rd_empty_err = 0;
      while (bd.size() < 200 && k < 5000) begin
         wr_en = (nw < 200) && (fcnt < 4'd8) && ($urandom_range(1, 0) == 1);
         wr_data = 8'($urandom);
         if (wr_en) begin
            ed.push_back(wr_data);
            nw++;
         end
         tready = ($urandom_range(1, 0) == 1);
         tick(1);
         k++;
      end
      wr_en  = 1'b0;
      tready = 1'b1;
      tick(3);
      checks++;
      if (bd.size() !== 200) begin
         errors++;
         $display("FAIL rnd_count: got %0d need 200", bd.size());
      end
      for (int i = 0; i < bd.size() && i < ed.size(); i++) begin
         if (bd[i] !== ed[i]) bad_d++;
         if (bl[i] !== (i % 4 == 3)) bad_l++;
      end
      checks++;
      if (bad_d !== 0) begin
         errors++;
         $display("FAIL rnd_order: got %0d bad words need 0", bad_d);
      end
      checks++;
      if (bad_l !== 0) begin
         errors++;
         $display("FAIL rnd_tlast: got %0d bad tlast need 0", bad_l);
      end
      checks++;
      if (rd_empty_err !== 0) begin
         errors++;
         $display("FAIL rnd_rd_empty: got %0d need 0", rd_empty_err);
      end
      checks++;
      if (stab_err !== 0) begin
         errors++;
         $display("FAIL rnd_stable: got %0d need 0", stab_err);
      end
      checks++;
      if (pkt_cnt !== 16'd54) begin
         errors++;
         $display("FAIL rnd_pkt: got %0d need 54", pkt_cnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] exp_d [4] = '{8'h34, 8'h35, 8'h36, 8'h37};
      tready = 1'b0;
      for (int i = 0; i < 6; i++) wr(8'h31 + 8'(i));
      tick(3);
      bd.delete(); bl.delete(); bc.delete();
      tready = 1'b1;
      tick(2);
      rst_n  = 1'b0;
      tready = 1'b0;
      #1;
      checks++;
      if (tvalid !== 1'b0 || tdata !== 8'h00 || tlast !== 1'b0 || pkt_cnt !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_out: got %b/%h/%b/%0d need 0/00/0/0",
                  tvalid, tdata, tlast, pkt_cnt);
      end
      checks++;
      if (bd.size() !== 2) begin
         errors++;
         $display("FAIL mid_pre_beats: got %0d need 2", bd.size());
      end
      checks++;
      if (fcnt !== 4'd3) begin
         errors++;
         $display("FAIL mid_fifo_kept: got %0d need 3", fcnt);
      end
      tick(2);
      rst_n = 1'b1;
      bd.delete(); bl.delete(); bc.delete();
      tready = 1'b1;
      wr(8'h37);
      wait_beats(4, 40, "mid_drain");
      tick(2);
      for (int i = 0; i < 4 && i < bd.size(); i++) begin
         checks++;
         if (bd[i] !== exp_d[i] || bl[i] !== (i == 3)) begin
            errors++;
            $display("FAIL mid_beat%0d: got %h/%b need %h/%b",
                     i, bd[i], bl[i], exp_d[i], (i == 3));
         end
      end
      checks++;
      if (pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL mid_pkt: got %0d need 1", pkt_cnt);
      end
   endtask

   task automatic test_pkt_len1;
      int k = 0;
      bbd.delete(); bbl.delete();
      b_en = 1'b1;
      while (bbd.size() < 5 && k < 40) begin
         tick(1);
         k++;
      end
      tick(2);
      checks++;
      if (bbd.size() !== 5) begin
         errors++;
         $display("FAIL p1_count: got %0d need 5", bbd.size());
      end
      for (int i = 0; i < 5 && i < bbd.size(); i++) begin
         checks++;
         if (bbd[i] !== 8'(i + 1) || bbl[i] !== 1'b1) begin
            errors++;
            $display("FAIL p1_beat%0d: got %h/%b need %h/1",
                     i, bbd[i], bbl[i], 8'(i + 1));
         end
      end
      checks++;
      if (pkt_cnt_b !== 16'd5) begin
         errors++;
         $display("FAIL p1_pkt: got %0d need 5", pkt_cnt_b);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      fclr     = 1'b1;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      tready   = 1'b0;
      tready_b = 1'b1;
      b_en     = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_random();
      test_reset_mid();
      test_pkt_len1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
